// File: rtl/tiny16_cpu_if.sv
// tiny16_cpu_if
//   Board-facing outputs of the tiny16 CPU, bundled so the top level and the
//   board wrapper (or testbench) share one connection point.
//
//   Signals
//     out    [15:0]  output-port register, changed only by the OUT instruction
//     usbpu          USB pull-up control, held low
//
//   Modports
//     master  - the CPU, which drives both signals
//     slave   - the board side / observer, which reads them
interface tiny16_cpu_if;
    logic [15:0] out;
    logic        usbpu;

    modport master (output out, output usbpu);
    modport slave  (input out, input usbpu);
endinterface

// File: rtl/tiny16_cpu.sv
// tiny16_cpu
//   Minimal 16-bit multi-cycle CPU with an internal word-addressed memory,
//   NREGS general-purpose registers, one shared internal bus and a 16-bit ALU.
//   Every instruction takes three clocks: fetch-address, fetch-data, execute.
//
//   Ports
//     clk   system clock, all state changes on the rising edge
//     rst   asynchronous active-high reset
//     io    tiny16_cpu_if.master: output-port register and USB pull-up
//
//   Instruction word: [15:12] opcode, [11:9] rd, [8] immediate flag,
//   [7:0] imm8 (zero-extended), [6:4] rs (register operand when flag is 0).
//
//   The memory array is never written by the CPU and is not cleared by reset;
//   programs are placed in it from outside before reset is released.
module tiny16_cpu #(
    parameter int MEM_DEPTH = 256,
    parameter int NREGS     = 8
) (
    input  logic            clk,
    input  logic            rst,
    tiny16_cpu_if.master    io
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_OUT = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_DATA = 2'd1,
        S_EXEC = 2'd2
    } step_t;

    logic [15:0] mem [MEM_DEPTH];
    logic [15:0] regs [NREGS];

    step_t       step;
    logic [15:0] pc;
    logic [AW-1:0] addr;
    logic [15:0] ir;
    logic [15:0] out_reg;
    logic        halted;

    logic [15:0] mem_out;
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic        imm_flag;
    logic [7:0]  imm8;
    logic [15:0] rd_val;
    logic [15:0] operand_b;
    logic [15:0] alu_result;
    logic        writes_reg;
    logic [15:0] bus;

    assign mem_out   = mem[addr];

    assign opcode    = ir[15:12];
    assign rd        = ir[11:9];
    assign imm_flag  = ir[8];
    assign imm8      = ir[7:0];
    assign rs        = ir[6:4];

    assign rd_val    = regs[rd];
    assign operand_b = imm_flag ? {8'h00, imm8} : regs[rs];

    // LD and the five ALU ops are the only instructions that write a register.
    assign writes_reg = (opcode == OP_LD)  || (opcode == OP_ADD) ||
                        (opcode == OP_SUB) || (opcode == OP_AND) ||
                        (opcode == OP_OR)  || (opcode == OP_XOR);

    // ALU: purely combinational from X[rd], operand B and the opcode.
    always_comb begin
        alu_result = rd_val;
        case (opcode)
            OP_ADD:  alu_result = rd_val + operand_b;
            OP_SUB:  alu_result = rd_val - operand_b;
            OP_AND:  alu_result = rd_val & operand_b;
            OP_OR:   alu_result = rd_val | operand_b;
            OP_XOR:  alu_result = rd_val ^ operand_b;
            default: alu_result = rd_val;
        endcase
    end

    // Shared bus: PC while addressing, memory data while fetching, and the
    // register write value (B for LD, ALU result otherwise) while executing.
    // Every register load below takes its value from this bus.
    always_comb begin
        bus = 16'h0000;
        case (step)
            S_ADDR: bus = pc;
            S_DATA: bus = mem_out;
            S_EXEC: begin
                if (opcode == OP_LD)
                    bus = operand_b;
                else if (writes_reg)
                    bus = alu_result;
            end
            default: bus = 16'h0000;
        endcase
    end

    // Sequencer and datapath state. Once halted, nothing changes until reset;
    // reset aborts any instruction in flight and restarts at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step    <= S_ADDR;
            pc      <= 16'h0000;
            addr    <= '0;
            ir      <= 16'h0000;
            out_reg <= 16'h0000;
            halted  <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= 16'h0000;
        end else if (!halted) begin
            case (step)
                S_ADDR: begin
                    addr <= bus[AW-1:0];
                    step <= S_DATA;
                end
                S_DATA: begin
                    ir   <= bus;
                    pc   <= pc + 16'd1;
                    step <= S_EXEC;
                end
                S_EXEC: begin
                    if (writes_reg)
                        regs[rd] <= bus;
                    case (opcode)
                        OP_OUT:  out_reg <= rd_val;
                        OP_JMP:  pc      <= operand_b;
                        OP_HLT:  halted  <= 1'b1;
                        default: ;
                    endcase
                    step <= S_ADDR;
                end
                default: step <= S_ADDR;
            endcase
        end
    end

    assign io.out   = out_reg;
    assign io.usbpu = 1'b0;

endmodule

// File: tb/tb_tiny16_cpu.sv
// tb_tiny16_cpu
//   Directed testbench for tiny16_cpu. Small programs are written into the
//   CPU memory while reset is held, then run for a known number of clocks and
//   compared against hand-computed register, PC and output values.
module tb_tiny16_cpu;

    logic clk;
    logic rst;

    int checkCount;
    int passCount;

    tiny16_cpu_if io ();

    tiny16_cpu dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, actual, expected);
    endtask

    // Run the CPU for a number of rising edges, then settle just past the edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Hold reset, wipe memory to NOP; the caller loads the program next.
    task automatic holdResetAndClear();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++)
            dut.mem[i] = 16'h0000;
    endtask

    // Keep reset for two clocks, then release it on a falling edge.
    task automatic releaseReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;

        // Reset state and load/add program
        holdResetAndClear();
        dut.mem[0] = 16'h1501;   // LD  X2,#1
        dut.mem[1] = 16'h1702;   // LD  X3,#2
        dut.mem[2] = 16'h3430;   // ADD X2,X3
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset pc", dut.pc, 16'h0000);
        checkOutput("reset step", 16'(dut.step), 16'h0000);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("reset X%0d", i), dut.regs[i], 16'h0000);
        checkOutput("reset out", io.out, 16'h0000);
        checkOutput("reset usbpu", 16'(io.usbpu), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1);
        checkOutput("fetch step1", 16'(dut.step), 16'h0001);
        checkOutput("fetch addr", 16'(dut.addr), 16'h0000);
        checkOutput("fetch mem_out", dut.mem_out, 16'h1501);
        applyStimulus(1);
        checkOutput("fetch ir", dut.ir, 16'h1501);
        checkOutput("fetch pc", dut.pc, 16'h0001);
        applyStimulus(1);
        checkOutput("ld X2", dut.regs[2], 16'h0001);
        applyStimulus(3);
        checkOutput("ld X3", dut.regs[3], 16'h0002);
        applyStimulus(3);
        checkOutput("add X2", dut.regs[2], 16'h0003);
        checkOutput("add X3", dut.regs[3], 16'h0002);
        for (int i = 0; i < 8; i++)
            if (i != 2 && i != 3)
                checkOutput($sformatf("add other X%0d", i), dut.regs[i], 16'h0000);
        checkOutput("add pc", dut.pc, 16'h0003);

        // Reset asserted in the middle of step 1 acts without a clock edge
        applyStimulus(1);
        checkOutput("mid step1", 16'(dut.step), 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid rst pc", dut.pc, 16'h0000);
        checkOutput("mid rst step", 16'(dut.step), 16'h0000);
        checkOutput("mid rst X2", dut.regs[2], 16'h0000);
        checkOutput("mid rst X3", dut.regs[3], 16'h0000);
        checkOutput("mid rst ir", dut.ir, 16'h0000);

        // Wraparound, logic ops and OUT
        holdResetAndClear();
        dut.mem[0] = 16'h13FF;   // LD  X1,#0xFF
        dut.mem[1] = 16'h3301;   // ADD X1,#1
        dut.mem[2] = 16'h4901;   // SUB X4,#1
        dut.mem[3] = 16'h2800;   // OUT X4
        dut.mem[4] = 16'h5240;   // AND X1,X4
        dut.mem[5] = 16'h630F;   // OR  X1,#0x0F
        dut.mem[6] = 16'h7240;   // XOR X1,X4
        dut.mem[7] = 16'h1010;   // LD  X0,X1
        releaseReset();
        applyStimulus(3);
        checkOutput("ld X1 ff", dut.regs[1], 16'h00FF);
        applyStimulus(3);
        checkOutput("add carry X1", dut.regs[1], 16'h0100);
        applyStimulus(3);
        checkOutput("sub wrap X4", dut.regs[4], 16'hFFFF);
        checkOutput("out before", io.out, 16'h0000);
        applyStimulus(3);
        checkOutput("out X4", io.out, 16'hFFFF);
        applyStimulus(3);
        checkOutput("and X1", dut.regs[1], 16'h0100);
        applyStimulus(3);
        checkOutput("or X1", dut.regs[1], 16'h010F);
        applyStimulus(3);
        checkOutput("xor X1", dut.regs[1], 16'hFEF0);
        applyStimulus(3);
        checkOutput("ld reg X0", dut.regs[0], 16'hFEF0);
        checkOutput("ld reg pc", dut.pc, 16'h0008);

        // Jump and halt
        holdResetAndClear();
        dut.mem[0] = 16'h8104;   // JMP #4
        dut.mem[1] = 16'h1B55;   // LD  X5,#0x55 (must be skipped)
        dut.mem[4] = 16'hF000;   // HLT
        releaseReset();
        applyStimulus(3);
        checkOutput("jmp pc", dut.pc, 16'h0004);
        applyStimulus(3);
        checkOutput("hlt pc", dut.pc, 16'h0005);
        checkOutput("hlt flag", 16'(dut.halted), 16'h0001);
        checkOutput("hlt step", 16'(dut.step), 16'h0000);
        applyStimulus(9);
        checkOutput("halted pc", dut.pc, 16'h0005);
        checkOutput("halted step", 16'(dut.step), 16'h0000);
        checkOutput("skipped X5", dut.regs[5], 16'h0000);

        // Undefined opcodes and NOP leave state alone
        holdResetAndClear();
        dut.mem[0] = 16'h1123;   // LD  X0,#0x23
        dut.mem[1] = 16'hA1FF;   // opcode A
        dut.mem[2] = 16'h0000;   // NOP
        dut.mem[3] = 16'hEFFF;   // opcode E, rd=7
        releaseReset();
        applyStimulus(3);
        checkOutput("undef setup X0", dut.regs[0], 16'h0023);
        checkOutput("undef pc1", dut.pc, 16'h0001);
        applyStimulus(3);
        checkOutput("opA X0", dut.regs[0], 16'h0023);
        checkOutput("opA pc", dut.pc, 16'h0002);
        applyStimulus(3);
        checkOutput("nop pc", dut.pc, 16'h0003);
        applyStimulus(3);
        checkOutput("opE X7", dut.regs[7], 16'h0000);
        checkOutput("opE X0", dut.regs[0], 16'h0023);
        checkOutput("opE out", io.out, 16'h0000);
        checkOutput("opE pc", dut.pc, 16'h0004);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/tiny16_cpu.md
Name: tiny16_cpu

Overview:
- Minimal 16-bit multi-cycle accumulator-free CPU with an internal word-addressed program/data memory, 8 general-purpose registers, a shared internal bus and a 16-bit ALU.
- Top-level block of the tiny16 FPGA design; its only outputs are an output-port register and the board USB pull-up control.
- Each instruction takes exactly 3 clock cycles: fetch-address, fetch-data, execute.

Parameters:
- MEM_DEPTH, 256, number of 16-bit words in internal memory. Addresses are PC modulo MEM_DEPTH.
- NREGS, 8, number of general-purpose registers X0..X7.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- OUT  output  16  output-port register, written only by the OUT instruction.
- USBPU  output  1  USB pull-up control; constant 0.

Behaviour:
- Reset (async, RST=1) clears the following to 0: PC, memory address register (addr), instruction register (IR), step counter, X0..X7, OUT and the halt flag.
- Memory contents are not cleared by reset. They power up as 0 (NOP) and are loadable by the bench via hierarchical writes before reset release.
- Memory read is combinational: mem_out = mem[addr].
- Instruction format:
  - [15:12] opcode
  - [11:9] rd
  - [8] immediate flag I
  - [7:0] imm8, zero-extended to 16 bits
  - [6:4] rs, used when I=0
- Step counter sequences 0→1→2→0; it holds when halted.
  - Step 0: bus=PC; addr<=PC.
  - Step 1: bus=mem_out; IR<=mem_out; PC<=PC+1 (16-bit wrap).
  - Step 2: execute the instruction in IR, as listed below.
- Operand B = imm8 if I=1, else X[rs].
- Opcodes:
  - 0x0 NOP: no state change.
  - 0x1 LD: X[rd]<=B.
  - 0x2 OUT: OUT<=X[rd].
  - 0x3 ADD: X[rd]<=X[rd]+B, mod 2^16, carry discarded.
  - 0x4 SUB: X[rd]<=X[rd]-B, mod 2^16.
  - 0x5 AND, 0x6 OR, 0x7 XOR: X[rd]<=X[rd] op B.
  - 0x8 JMP: PC<=B.
  - 0xF HLT: set halt flag; step counter and PC freeze until reset.
  - 0x9–0xE: execute as NOP.
- The ALU output is combinational from X[rd], B and opcode. During step 2 of ALU ops the bus carries the ALU result; for LD it carries B.
- Only one register is written per instruction. X0 is an ordinary writable register.
- Reset asserted mid-instruction aborts it immediately; execution restarts at address 0, step 0.

Test Plan:
- Reset: hold RST for 2 cycles → PC=0, step=0, X0..X7=0, OUT=0, USBPU=0. Assert RST mid-step-1 → same values immediately, without waiting for a clock.
- Load/add program: mem[0]=0x1501 (LD X2,#1), mem[1]=0x1702 (LD X3,#2), mem[2]=0x3430 (ADD X2,X3). Release reset.
  - After 3 cycles: X2=1.
  - After 6 cycles: X3=2.
  - After 9 cycles: X2=3, X3=2, all other registers 0, PC=3.
- Fetch timing: during step 1 of the first instruction → addr=0, mem_out=0x1501. After that edge → IR=0x1501, PC=1.
- Wrap and output:
  - LD X1,#0xFF; ADD X1,#1 → X1=0x0100.
  - SUB X4,#1 from X4=0 → 0xFFFF.
  - OUT X4 → OUT=0xFFFF.
- Control flow: mem[0]=JMP #4, mem[4]=HLT. After 6 cycles → PC=5, halted. Further clocks → PC and step unchanged; the instruction at mem[1] is never executed.
- Undefined opcode 0xA and NOP → no register or OUT change; PC advances by 1 every 3 cycles.
